// File: rtl/manchester_cmd_if.sv
// manchester_cmd_if: sequencer <-> Manchester command transmitter handshake and status bundle
interface manchester_cmd_if;
    logic [2:0]  command_1;
    logic        start;
    logic        ready_command;
    logic        tx_out;
    logic        tx_active;
    logic        cmd_err;
    logic [15:0] frame_cnt;
    modport master (output command_1, start, input ready_command, tx_out, tx_active, cmd_err, frame_cnt);
    modport slave  (input command_1, start, output ready_command, tx_out, tx_active, cmd_err, frame_cnt);
endinterface

// File: rtl/manchester_cmd_tx.sv
// manchester_cmd_tx: maps a command code to a payload and sends preamble+payload+parity Manchester-encoded
module manchester_cmd_tx #(
    parameter int         HALF_BIT_CLKS = 2500,
    parameter logic [7:0] PREAMBLE      = 8'hA5
) (
    input logic             clk,
    input logic             rst,
    manchester_cmd_if.slave bus
);
    localparam int CW = $clog2(HALF_BIT_CLKS) + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_FIRST = 2'd1, S_SECOND = 2'd2, S_ERR = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [16:0]   sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [15:0]   frame_q, frame_d;
    logic          start_d_q, ready_q, ready_d, tx_q, tx_d, act_q, act_d, err_q, err_d;
    logic [7:0]    payload;
    logic [16:0]   load;
    logic          start_edge, half_done;
    assign start_edge = bus.start & ~start_d_q;
    assign half_done  = cnt_q == CW'(HALF_BIT_CLKS - 1);
    assign payload    = bus.command_1 == 3'd4 ? 8'hFF : 8'h11 << bus.command_1[1:0];
    assign load       = {^payload, payload, PREAMBLE};
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        ready_d = ready_q;
        tx_d    = tx_q;
        act_d   = act_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                tx_d    = 1'b0;
                act_d   = 1'b0;
                err_d   = 1'b0;
                if (start_edge && bus.command_1 <= 3'd4) begin
                    sh_d    = load;
                    cnt_d   = '0;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    act_d   = 1'b1;
                    tx_d    = ~load[0];
                    state_d = S_FIRST;
                end else if (start_edge) begin
                    ready_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_FIRST: begin
                cnt_d = half_done ? '0 : cnt_q + 1'b1;
                if (half_done) begin
                    tx_d    = sh_q[0];
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                cnt_d = half_done ? '0 : cnt_q + 1'b1;
                if (half_done && idx_q < 5'd16) begin
                    sh_d    = sh_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    tx_d    = ~sh_q[1];
                    state_d = S_FIRST;
                end else if (half_done) begin
                    tx_d    = 1'b0;
                    act_d   = 1'b0;
                    ready_d = 1'b1;
                    frame_d = frame_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                err_d   = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                tx_d    = 1'b0;
                act_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            start_d_q <= 1'b0;
            ready_q   <= 1'b1;
            tx_q      <= 1'b0;
            act_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            start_d_q <= bus.start;
            ready_q   <= ready_d;
            tx_q      <= tx_d;
            act_q     <= act_d;
            err_q     <= err_d;
        end
    end
    assign bus.ready_command = ready_q;
    assign bus.tx_out        = tx_q;
    assign bus.tx_active     = act_q;
    assign bus.cmd_err       = err_q;
    assign bus.frame_cnt     = frame_q;
endmodule
